// File: rtl/host_loader_if.sv
// Host word stream: 32-bit valid/ready channel from the host into the loader.
interface host_loader_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/host_loader.sv
// Host-facing loader: decodes command headers from the host word stream,
// writes instruction words, packs shared-memory lines, and issues START.
module host_loader #(
    parameter int IMEM_AW = 8,
    parameter int SHM_AW  = 6,
    parameter int LANES   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    host_loader_if.slave          host,
    input  logic                  clear,
    input  logic                  done,
    output logic                  imem_we,
    output logic [IMEM_AW-1:0]    imem_a,
    output logic [27:0]           imem_d,
    output logic                  shm_we,
    output logic [SHM_AW-1:0]     shm_a,
    output logic [LANES*32-1:0]   shm_d,
    output logic                  start,
    output logic                  busy,
    output logic                  err
);
    localparam int          LW        = $clog2(LANES);
    localparam int          PW        = (LANES - 1) * 32;
    localparam logic [8:0]  SHM_LINES = 9'(2 ** SHM_AW);

    typedef enum logic [2:0] {S_HDR, S_IMEM, S_SHM, S_RUN, S_ERR} state_t;

    state_t               r_state, w_nstate;
    logic                 r_ready, w_nready;
    logic [IMEM_AW-1:0]   r_ptr, w_ptr;
    logic [8:0]           r_rem, w_rem;
    logic [LW-1:0]        r_lane, w_lane;
    logic [PW-1:0]        r_part, w_part;
    logic                 r_iwe, w_iwe;
    logic [IMEM_AW-1:0]   r_ia, w_ia;
    logic [27:0]          r_id, w_id;
    logic                 r_swe, w_swe;
    logic [SHM_AW-1:0]    r_sa, w_sa;
    logic [LANES*32-1:0]  r_sd, w_sd;
    logic                 r_start, w_start;

    logic                 w_acc;
    logic [1:0]           w_cmd;
    logic [8:0]           w_cnt;
    logic [7:0]           w_base;
    logic [SHM_AW-1:0]    w_sptr_inc;

    assign w_acc      = host.in_valid && r_ready;
    assign w_cmd      = host.in_data[31:30];
    assign w_cnt      = host.in_data[16:8];
    assign w_base     = host.in_data[7:0];
    assign w_sptr_inc = r_ptr[SHM_AW-1:0] + SHM_AW'(1);

    // Next-state and next-output decode; all outputs are registered below.
    always_comb begin
        w_nstate = r_state;
        w_ptr    = r_ptr;
        w_rem    = r_rem;
        w_lane   = r_lane;
        w_part   = r_part;
        w_iwe    = 1'b0;
        w_ia     = r_ia;
        w_id     = r_id;
        w_swe    = 1'b0;
        w_sa     = r_sa;
        w_sd     = r_sd;
        w_start  = 1'b0;
        case (r_state)
            S_HDR: if (w_acc) begin
                w_ptr  = IMEM_AW'(w_base);
                w_rem  = w_cnt;
                w_lane = '0;
                if (w_cmd == 2'd0 && w_cnt != 9'd0)
                    w_nstate = S_IMEM;
                else if (w_cmd == 2'd1 && w_cnt != 9'd0 && w_cnt <= SHM_LINES &&
                         (w_base >> SHM_AW) == 8'd0)
                    w_nstate = S_SHM;
                else if (w_cmd == 2'd2) begin
                    w_nstate = S_RUN;
                    w_start  = 1'b1;
                end else
                    w_nstate = S_ERR;
            end
            S_IMEM: if (w_acc) begin
                w_iwe = 1'b1;
                w_ia  = r_ptr;
                w_id  = host.in_data[27:0];
                w_ptr = r_ptr + IMEM_AW'(1);
                w_rem = r_rem - 9'd1;
                if (r_rem == 9'd1) w_nstate = S_HDR;
            end
            S_SHM: if (w_acc) begin
                if (r_lane == LW'(LANES - 1)) begin
                    // Last lane completes the line; earlier lanes sit in r_part.
                    w_swe  = 1'b1;
                    w_sa   = r_ptr[SHM_AW-1:0];
                    w_sd   = {host.in_data, r_part};
                    w_ptr  = IMEM_AW'(w_sptr_inc);
                    w_lane = '0;
                    w_rem  = r_rem - 9'd1;
                    if (r_rem == 9'd1) w_nstate = S_HDR;
                end else begin
                    w_part[r_lane*32 +: 32] = host.in_data;
                    w_lane = r_lane + LW'(1);
                end
            end
            S_RUN: if (done) w_nstate = S_HDR;
            S_ERR: if (clear) begin
                w_nstate = S_HDR;
                w_ptr    = '0;
                w_lane   = '0;
            end
            default: w_nstate = S_HDR;
        endcase
        w_nready = (w_nstate == S_HDR) || (w_nstate == S_IMEM) || (w_nstate == S_SHM);
    end

    // State, datapath and output registers; reset discards any partial line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_HDR;
            r_ready <= 1'b0;
            r_ptr   <= '0;
            r_rem   <= '0;
            r_lane  <= '0;
            r_part  <= '0;
            r_iwe   <= 1'b0;
            r_ia    <= '0;
            r_id    <= '0;
            r_swe   <= 1'b0;
            r_sa    <= '0;
            r_sd    <= '0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_ready <= w_nready;
            r_ptr   <= w_ptr;
            r_rem   <= w_rem;
            r_lane  <= w_lane;
            r_part  <= w_part;
            r_iwe   <= w_iwe;
            r_ia    <= w_ia;
            r_id    <= w_id;
            r_swe   <= w_swe;
            r_sa    <= w_sa;
            r_sd    <= w_sd;
            r_start <= w_start;
        end
    end

    assign host.in_ready = r_ready;
    assign imem_we = r_iwe;
    assign imem_a  = r_ia;
    assign imem_d  = r_id;
    assign shm_we  = r_swe;
    assign shm_a   = r_sa;
    assign shm_d   = r_sd;
    assign start   = r_start;
    assign busy    = (r_state != S_HDR);
    assign err     = (r_state == S_ERR);
endmodule
